master_req_queue: RTL and testbench

Per-master request queue feeding one master port of the two-slave crossbar. Buffers up to DEPTH requests from a master core, presents them one at a time on the crossbar's req/cmd/addr/wdata port, holds each until the crossbar returns ack, and emits one response per request carrying captured rdata. One instance sits directly upstream of each crossbar master port.

---
 rtl/crossbar_pkg.sv | 27 ++
 rtl/master_req_queue_if.sv | 44 ++++
 rtl/master_req_queue_sync_fifo.sv | 53 +++++
 rtl/master_req_queue.sv | 146 ++++++++++++++
 tb/tb_master_req_queue.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/crossbar_pkg.sv
// Shared crossbar types: command encoding, bus widths, request word, queue FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Ports: none (package).
package crossbar_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  // One buffered request as it travels from the master core to the crossbar.
  typedef struct packed {
    logic              cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  localparam int REQ_W = $bits(req_t);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

endpackage

// File: rtl/master_req_queue_if.sv
// Bundle of all master_req_queue handshake/bus signals: upstream request, crossbar port, response.
// Latency: n/a (wiring only).
// Backpressure: in_ready towards upstream; crossbar side holds req until ack; response has none.
// Ports: modport slave = the queue; modport master = upstream core plus crossbar (or a bench).
interface master_req_queue_if #(
  parameter int DEPTH = 4
);
  import crossbar_pkg::*;

  // upstream request
  logic              in_valid;
  logic              in_ready;
  logic              in_cmd;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;

  // crossbar master port
  logic              req;
  logic              cmd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  // response and status
  logic              resp_valid;
  logic              resp_cmd;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic [$clog2(DEPTH):0] level;

  modport slave (
    input  in_valid, in_cmd, in_addr, in_wdata, ack, rdata,
    output in_ready, req, cmd, addr, wdata,
    output resp_valid, resp_cmd, resp_rdata, resp_err, level
  );

  modport master (
    output in_valid, in_cmd, in_addr, in_wdata, ack, rdata,
    input  in_ready, req, cmd, addr, wdata,
    input  resp_valid, resp_cmd, resp_rdata, resp_err, level
  );

endinterface

// File: rtl/master_req_queue_sync_fifo.sv
// sync_fifo: generic synchronous FIFO, first-word-fall-through read port.
// Latency: pushed word visible at pop_dat one cycle after the push edge.
// Backpressure: push ignored while full (even if popping that cycle); pop ignored while empty.
// Ports: clk, rst (sync, active-high), push/push_dat, pop/pop_dat, full, empty, level (0..DEPTH).
module sync_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers carry one extra wrap bit so that full and empty are distinguishable.
  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == PW'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: contents are only read behind a valid pointer.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/master_req_queue.sv
// Per-master request queue: buffers DEPTH requests, issues them one at a time to a crossbar port, returns one response each.
// Latency: push-to-req 2 cycles on an empty idle queue; ack-to-resp_valid 1 cycle; at least one req-low cycle between requests.
// Backpressure: in_ready = !full upstream; req held until ack (or timeout abort); resp_valid has no backpressure.
// Ports: clk, rst (sync, active-high), bus (master_req_queue_if.slave: in_*, req/cmd/addr/wdata/ack/rdata, resp_*, level).
// Optional: define MASTER_REQ_QUEUE_TIMEOUT_EN to abort a request after TIMEOUT REQ cycles without ack (resp_err=1).
module master_req_queue
  import crossbar_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  master_req_queue_if.slave bus
);

  localparam int LW = $clog2(DEPTH) + 1;

  state_t        state;
  state_t        state_d;
  req_t          in_req;
  req_t          head;
  req_t          cur;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;
  logic          push;
  logic          pop;
  logic          fire;
  logic          err_d;
  logic          tmo_hit;

  assign in_req = '{cmd: bus.in_cmd, addr: bus.in_addr, wdata: bus.in_wdata};
  assign push   = bus.in_valid && !fifo_full;

  assign bus.in_ready = !fifo_full;
  assign bus.level    = fifo_level;

  sync_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (in_req),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

`ifdef MASTER_REQ_QUEUE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] tmo_cnt;
  logic          resp_err_q;

  // Counter value is (REQ cycles elapsed - 1), so expiry lands on the TIMEOUT-th REQ cycle.
  assign tmo_hit = (state == ST_REQ) && (tmo_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || pop) begin
      tmo_cnt <= '0;
    end else if ((state == ST_REQ) && !bus.ack) begin
      tmo_cnt <= tmo_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_err_q <= 1'b0;
    end else if (fire) begin
      resp_err_q <= err_d;
    end
  end

  assign bus.resp_err = resp_err_q;
`else
  wire unused_timeout = ^TIMEOUT;

  assign tmo_hit      = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // ack has priority over a same-cycle timeout so a late but valid completion is not lost.
  always_comb begin
    state_d = state;
    pop     = 1'b0;
    fire    = 1'b0;
    err_d   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.ack) begin
          fire    = 1'b1;
          state_d = ST_IDLE;
        end else if (tmo_hit) begin
          fire    = 1'b1;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.req   = (state == ST_REQ);
  assign bus.cmd   = cur.cmd;
  assign bus.addr  = cur.addr;
  assign bus.wdata = cur.wdata;

  // cur holds the in-flight request stable for the whole REQ phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur            <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_cmd   <= CMD_READ;
      bus.resp_rdata <= '0;
    end else begin
      bus.resp_valid <= fire;
      if (pop) begin
        cur <= head;
      end
      if (fire) begin
        bus.resp_cmd   <= cur.cmd;
        bus.resp_rdata <= (!err_d && (cur.cmd == CMD_READ)) ? bus.rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_master_req_queue.sv
// Directed bench for master_req_queue: reset, single read, stray ack, back-to-back, fill, mid-REQ reset, timeout.
// Latency: n/a (bench).
// Backpressure: bench plays the crossbar and acks when it chooses.
module tb_master_req_queue;
  import crossbar_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  master_req_queue_if #(.DEPTH(DEPTH)) bus();

  master_req_queue #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         passes = 0;
  int         n;
  int         idx;
  int         nxt;
  int         resps;
  logic       rdy;
  logic [9:0] hist;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic c, input logic [31:0] a, input logic [31:0] d);
    bus.in_valid = v;
    bus.in_cmd   = c;
    bus.in_addr  = a;
    bus.in_wdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    drive_in(1'b0, CMD_READ, 32'h0, 32'h0);
    bus.ack   = 1'b0;
    bus.rdata = 32'h0;
    rst       = 1'b1;
    cycle();
    cycle();

    // reset state
    chk("rst_req",        32'(bus.req),        32'h0);
    chk("rst_level",      32'(bus.level),      32'h0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst_resp_err",   32'(bus.resp_err),   32'h0);
    chk("rst_addr",       bus.addr,            32'h0);
    chk("rst_resp_rdata", bus.resp_rdata,      32'h0);
    rst = 1'b0;
    cycle();
    chk("rst_in_ready",   32'(bus.in_ready),   32'h1);

    // single read, ack on third req cycle
    drive_in(1'b1, CMD_READ, 32'h0000_0010, 32'h0);
    cycle();
    drive_in(1'b0, CMD_READ, 32'h0, 32'h0);
    chk("rd_level_after_push", 32'(bus.level), 32'h1);
    chk("rd_req_before_pop",   32'(bus.req),   32'h0);
    cycle();
    chk("rd_req_first", 32'(bus.req), 32'h1);
    chk("rd_addr",      bus.addr,     32'h0000_0010);
    chk("rd_cmd",       32'(bus.cmd), 32'h0);
    n = 1;
    repeat (2) begin
      cycle();
      n += int'(bus.req);
    end
    bus.ack   = 1'b1;
    bus.rdata = 32'hDEAD_BEEF;
    cycle();
    bus.ack   = 1'b0;
    bus.rdata = 32'h0;
    chk("rd_req_cycles", n,                   3);
    chk("rd_req_low",    32'(bus.req),        32'h0);
    chk("rd_resp_valid", 32'(bus.resp_valid), 32'h1);
    chk("rd_resp_rdata", bus.resp_rdata,      32'hDEAD_BEEF);
    chk("rd_resp_cmd",   32'(bus.resp_cmd),   32'h0);
    chk("rd_resp_err",   32'(bus.resp_err),   32'h0);
    cycle();
    chk("rd_resp_pulse", 32'(bus.resp_valid), 32'h0);

    // stray ack while idle and empty
    bus.ack = 1'b1;
    cycle();
    bus.ack = 1'b0;
    chk("stray_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("stray_level",      32'(bus.level),      32'h0);
    chk("stray_req",        32'(bus.req),        32'h0);
    cycle();
    chk("stray_resp_late",  32'(bus.resp_valid), 32'h0);

    // back-to-back writes, crossbar acks on the first req cycle
    hist  = '0;
    resps = 0;
    nxt   = 0;
    bus.rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      hist[i] = bus.req;
      if (bus.resp_valid) begin
        resps++;
        chk("b2b_resp_rdata", bus.resp_rdata,    32'h0);
        chk("b2b_resp_cmd",   32'(bus.resp_cmd), 32'h1);
      end
      if (bus.req) begin
        chk("b2b_addr",  bus.addr,  32'h8000_0100 + 32'(nxt));
        chk("b2b_wdata", bus.wdata, 32'h1111_0000 + 32'(nxt));
        nxt++;
      end
      if (i < 3) drive_in(1'b1, CMD_WRITE, 32'h8000_0100 + 32'(i), 32'h1111_0000 + 32'(i));
      else       drive_in(1'b0, CMD_WRITE, 32'h0, 32'h0);
      bus.ack = bus.req;
      cycle();
    end
    bus.ack = 1'b0;
    chk("b2b_req_pattern", 32'(hist), 32'h0000_0054);
    chk("b2b_resp_count",  resps,     3);
    chk("b2b_issued",      nxt,       3);

    // fill: offer 6 writes with no ack; 1 in REQ + 4 queued, 6th held
    idx = 0;
    drive_in(1'b1, CMD_WRITE, 32'h0000_0200, 32'h0);
    for (int i = 0; i < 8; i++) begin
      rdy = bus.in_ready;
      cycle();
      if (rdy) idx++;
      drive_in(1'b1, CMD_WRITE, 32'h0000_0200 + 32'(idx * 4), 32'(idx));
    end
    chk("fill_accepted", idx,                5);
    chk("fill_level",    32'(bus.level),     32'h4);
    chk("fill_in_ready", 32'(bus.in_ready),  32'h0);
    chk("fill_req",      32'(bus.req),       32'h1);
    chk("fill_addr0",    bus.addr,           32'h0000_0200);
    bus.ack   = 1'b1;
    bus.rdata = 32'hA5A5_A5A5;
    cycle();
    bus.ack = 1'b0;
    chk("fill_resp0_valid", 32'(bus.resp_valid), 32'h1);
    chk("fill_resp0_rdata", bus.resp_rdata,      32'h0);
    chk("fill_gap_req",     32'(bus.req),        32'h0);
    chk("fill_still_full",  32'(bus.in_ready),   32'h0);
    cycle();
    chk("fill_req1",        32'(bus.req),        32'h1);
    chk("fill_addr1",       bus.addr,            32'h0000_0204);
    chk("fill_level_pop",   32'(bus.level),      32'h3);
    chk("fill_ready_again", 32'(bus.in_ready),   32'h1);
    cycle();
    drive_in(1'b0, CMD_WRITE, 32'h0, 32'h0);
    chk("fill_level_6th",   32'(bus.level),      32'h4);
    resps = 1;
    nxt   = 1;
    for (int i = 0; i < 40; i++) begin
      if (bus.req) begin
        chk("fill_order_addr", bus.addr, 32'h0000_0200 + 32'(nxt * 4));
        nxt++;
      end
      bus.ack = bus.req;
      cycle();
      if (bus.resp_valid) begin
        resps++;
        chk("fill_resp_rdata", bus.resp_rdata, 32'h0);
      end
    end
    bus.ack = 1'b0;
    chk("fill_issued",     nxt,            6);
    chk("fill_resp_count", resps,          6);
    chk("fill_drained",    32'(bus.level), 32'h0);

    // reset while a request is in REQ and two are queued
    for (int i = 0; i < 3; i++) begin
      drive_in(1'b1, CMD_READ, 32'h0000_0300 + 32'(i), 32'h0);
      cycle();
    end
    drive_in(1'b0, CMD_READ, 32'h0, 32'h0);
    chk("rm_level_before", 32'(bus.level), 32'h2);
    chk("rm_req_before",   32'(bus.req),   32'h1);
    rst = 1'b1;
    cycle();
    chk("rm_req",        32'(bus.req),        32'h0);
    chk("rm_level",      32'(bus.level),      32'h0);
    chk("rm_resp_valid", 32'(bus.resp_valid), 32'h0);
    rst = 1'b0;
    cycle();
    chk("rm_in_ready",   32'(bus.in_ready),   32'h1);
    chk("rm_req_after",  32'(bus.req),        32'h0);
    chk("rm_no_resp",    32'(bus.resp_valid), 32'h0);
    cycle();
    chk("rm_req_idle",   32'(bus.req),        32'h0);
    chk("rm_level_idle", 32'(bus.level),      32'h0);
    chk("rm_no_resp2",   32'(bus.resp_valid), 32'h0);

`ifdef MASTER_REQ_QUEUE_TIMEOUT_EN
    // no ack: abort after TIMEOUT REQ cycles
    bus.rdata = 32'hFFFF_FFFF;
    drive_in(1'b1, CMD_READ, 32'h0000_0400, 32'h0);
    cycle();
    drive_in(1'b0, CMD_READ, 32'h0, 32'h0);
    cycle();
    n = 1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (!bus.req) break;
      n++;
    end
    chk("tmo_req_cycles", n,                   TIMEOUT);
    chk("tmo_resp_valid", 32'(bus.resp_valid), 32'h1);
    chk("tmo_resp_err",   32'(bus.resp_err),   32'h1);
    chk("tmo_resp_rdata", bus.resp_rdata,      32'h0);
    cycle();
    chk("tmo_resp_pulse", 32'(bus.resp_valid), 32'h0);

    // ack on the expiry cycle wins
    drive_in(1'b1, CMD_READ, 32'h0000_0404, 32'h0);
    cycle();
    drive_in(1'b0, CMD_READ, 32'h0, 32'h0);
    cycle();
    n = 1;
    for (int i = 0; i < 30; i++) begin
      if (n == TIMEOUT) begin
        bus.ack   = 1'b1;
        bus.rdata = 32'h1234_5678;
      end
      cycle();
      bus.ack = 1'b0;
      if (!bus.req) break;
      n++;
    end
    chk("tmo_ack_cycles", n,                   TIMEOUT);
    chk("tmo_ack_valid",  32'(bus.resp_valid), 32'h1);
    chk("tmo_ack_err",    32'(bus.resp_err),   32'h0);
    chk("tmo_ack_rdata",  bus.resp_rdata,      32'h1234_5678);
`else
    // without the timeout feature REQ waits for ack indefinitely
    drive_in(1'b1, CMD_READ, 32'h0000_0404, 32'h0);
    cycle();
    drive_in(1'b0, CMD_READ, 32'h0, 32'h0);
    cycle();
    n = 1;
    for (int i = 0; i < 19; i++) begin
      cycle();
      n += int'(bus.req);
    end
    chk("wait_req_cycles", n,                   20);
    chk("wait_no_resp",    32'(bus.resp_valid), 32'h0);
    bus.ack   = 1'b1;
    bus.rdata = 32'h1234_5678;
    cycle();
    bus.ack = 1'b0;
    chk("wait_resp_valid", 32'(bus.resp_valid), 32'h1);
    chk("wait_resp_err",   32'(bus.resp_err),   32'h0);
    chk("wait_resp_rdata", bus.resp_rdata,      32'h1234_5678);
`endif

    cycle();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
